// File: rtl/bus_control_fsm.sv
// Instruction-sequencing control unit for the 16-bit shared-bus processor.
// Latches a 9-bit instruction {III,XXX,YYY} from DIN in T0. It then steps
// T1..T3 and drives the bus-source selects and the destination load enables
// for mv, mvi, add and sub.
module bus_control_fsm #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [IR_W-1:0]   IR,
  output logic [7:0]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done,
  output logic              Busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t            r_state;
  logic [IR_W-1:0]   r_ir;

  logic [2:0]        w_op;
  logic [2:0]        w_x;
  logic [2:0]        w_y;
  logic              w_is_arith;
  logic              w_unused_din;

  // The low DIN bits carry immediate data for the datapath, not the instruction.
  assign w_unused_din = ^DIN[DATA_W-IR_W-1:0];

  assign w_op       = r_ir[8:6];
  assign w_x        = r_ir[5:3];
  assign w_y        = r_ir[2:0];
  assign w_is_arith = (w_op == OP_ADD) || (w_op == OP_SUB);

  // Register select: Rk maps to bit (7-k).
  function automatic logic [7:0] sel(input logic [2:0] n);
    return 8'b1000_0000 >> n;
  endfunction

  // State and instruction register. IR is loaded only in T0 when Run is seen.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      case (r_state)
        T0: begin
          if (Run) begin
            r_ir    <= DIN[DATA_W-1 -: IR_W];
            r_state <= T1;
          end
        end
        T1:      r_state <= w_is_arith ? T2 : T0;
        T2:      r_state <= w_is_arith ? T3 : T0;
        T3:      r_state <= T0;
        default: r_state <= T0;
      endcase
    end
  end

  // Control outputs decoded from {state, IR}. All outputs are held at 0 while reset is asserted.
  always_comb begin
    IR     = '0;
    Rout   = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Rin    = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
    Busy   = 1'b0;
    if (Resetn) begin
      IR   = r_ir;
      Busy = (r_state != T0);
      case (r_state)
        T1: begin
          case (w_op)
            OP_MV: begin
              Rout = sel(w_y);
              Rin  = sel(w_x);
              Done = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = sel(w_x);
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout = sel(w_x);
              Ain  = 1'b1;
            end
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          if (w_is_arith) begin
            Rout   = sel(w_y);
            Gin    = 1'b1;
            AddSub = (w_op == OP_SUB);
          end
        end
        T3: begin
          if (w_is_arith) begin
            Gout = 1'b1;
            Rin  = sel(w_x);
            Done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_fsm.sv
// Bench for bus_control_fsm. A directed vector table with hand-computed
// expectations runs first. A long randomized run follows, checked against a
// micro-step queue model of each instruction.
module tb_bus_control_fsm;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] DIN;
  logic [8:0]  IR;
  logic [7:0]  Rout;
  logic        Gout;
  logic        DINout;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic        Busy;

  bus_control_fsm #(.DATA_W(16), .IR_W(9)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .DIN    (DIN),
    .IR     (IR),
    .Rout   (Rout),
    .Gout   (Gout),
    .DINout (DINout),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done),
    .Busy   (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [8:0] ir;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       busy;
  } outs_t;

  typedef struct {
    logic        rn;
    logic        run;
    logic [15:0] din;
    outs_t       exp;
  } vec_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a queue of the micro-steps still to be executed for the
  // current instruction. An empty queue means the unit is idle.
  outs_t      mq[$];
  logic [8:0] m_ir;

  function automatic outs_t mk(input logic [8:0] ir, input logic [7:0] rout,
                               input logic gout, input logic dinout,
                               input logic [7:0] rin, input logic ain,
                               input logic gin, input logic addsub,
                               input logic done, input logic busy);
    outs_t o;
    o.ir = ir; o.rout = rout; o.gout = gout; o.dinout = dinout; o.rin = rin;
    o.ain = ain; o.gin = gin; o.addsub = addsub; o.done = done; o.busy = busy;
    return o;
  endfunction

  function automatic logic [7:0] reg_bit(input int unsigned k);
    logic [7:0] v;
    v = '0;
    v[7 - k] = 1'b1;
    return v;
  endfunction

  task automatic load_program(input logic [8:0] ir);
    int unsigned op;
    int unsigned x;
    int unsigned y;
    op = int'(ir[8:6]);
    x  = int'(ir[5:3]);
    y  = int'(ir[2:0]);
    mq.delete();
    if (op == 0)
      mq.push_back(mk(ir, reg_bit(y), 0, 0, reg_bit(x), 0, 0, 0, 1, 1));
    else if (op == 1)
      mq.push_back(mk(ir, '0, 0, 1, reg_bit(x), 0, 0, 0, 1, 1));
    else if (op == 2 || op == 3) begin
      mq.push_back(mk(ir, reg_bit(x), 0, 0, '0, 1, 0, 0, 0, 1));
      mq.push_back(mk(ir, reg_bit(y), 0, 0, '0, 0, 1, (op == 3), 0, 1));
      mq.push_back(mk(ir, '0, 1, 0, reg_bit(x), 0, 0, 0, 1, 1));
    end else
      mq.push_back(mk(ir, '0, 0, 0, '0, 0, 0, 0, 1, 1));
  endtask

  function automatic outs_t model_expect(input logic rn);
    if (!rn) return '0;
    if (mq.size() == 0) return mk(m_ir, '0, 0, 0, '0, 0, 0, 0, 0, 0);
    return mq[0];
  endfunction

  task automatic model_edge(input logic rn, input logic run, input logic [15:0] din);
    if (!rn) begin
      mq.delete();
      m_ir = '0;
    end else if (mq.size() == 0) begin
      if (run) begin
        m_ir = din[15:7];
        load_program(m_ir);
      end
    end else
      void'(mq.pop_front());
  endtask

  task automatic check(input string name, input outs_t got, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample mid-low-phase, then let
  // the model follow the rising edge the DUT is about to see.
  task automatic step(input logic rn, input logic run, input logic [15:0] din,
                      output outs_t got);
    logic ok;
    @(negedge Clock);
    Resetn = rn;
    Run    = run;
    DIN    = din;
    #2;
    got = {IR, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, Busy};
    check("model", got, model_expect(rn));
    ok = (((Rout != 0) ? 1 : 0) + int'(Gout) + int'(DINout) <= 1) &&
         ($countones(Rout) <= 1) && ($countones(Rin) <= 1);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL bus_excl got Rout=%b Gout=%b DINout=%b Rin=%b exp exclusive", Rout, Gout, DINout, Rin);
    end
    model_edge(rn, run, din);
  endtask

  vec_t  tbl[26];
  outs_t got;

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    DIN    = '0;
    m_ir   = '0;

    tbl[0]  = '{0, 1, 16'hFFFF,               mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 1, 16'hFFFF,               mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1, 0, {9'b000_010_101, 7'd0}, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[3]  = '{1, 0, {9'b000_010_101, 7'd0}, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[4]  = '{1, 1, {9'b000_010_101, 7'd0}, mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[5]  = '{1, 0, 16'h0000,               mk(9'h015, 8'h04, 0, 0, 8'h20, 0, 0, 0, 1, 1)};
    tbl[6]  = '{1, 0, 16'h0000,               mk(9'h015, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[7]  = '{1, 1, {9'b001_000_000, 7'd0}, mk(9'h015, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1, 0, 16'h00A5,               mk(9'h040, 8'h00, 0, 1, 8'h80, 0, 0, 0, 1, 1)};
    tbl[9]  = '{1, 1, {9'b011_001_111, 7'd0}, mk(9'h040, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[10] = '{1, 1, 16'h0000,               mk(9'h0CF, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 1)};
    tbl[11] = '{1, 1, 16'h0000,               mk(9'h0CF, 8'h01, 0, 0, 8'h00, 0, 1, 1, 0, 1)};
    tbl[12] = '{1, 0, 16'h0000,               mk(9'h0CF, 8'h00, 1, 0, 8'h40, 0, 0, 0, 1, 1)};
    tbl[13] = '{1, 1, {9'b010_011_011, 7'd0}, mk(9'h0CF, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[14] = '{1, 1, {9'b000_000_001, 7'd0}, mk(9'h09B, 8'h10, 0, 0, 8'h00, 1, 0, 0, 0, 1)};
    tbl[15] = '{1, 1, {9'b000_000_001, 7'd0}, mk(9'h09B, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0, 1)};
    tbl[16] = '{1, 1, {9'b000_000_001, 7'd0}, mk(9'h09B, 8'h00, 1, 0, 8'h10, 0, 0, 0, 1, 1)};
    tbl[17] = '{1, 1, {9'b000_000_001, 7'd0}, mk(9'h09B, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[18] = '{1, 1, {9'b110_101_010, 7'd0}, mk(9'h001, 8'h40, 0, 0, 8'h80, 0, 0, 0, 1, 1)};
    tbl[19] = '{1, 1, {9'b110_101_010, 7'd0}, mk(9'h001, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[20] = '{1, 0, 16'h0000,               mk(9'h1AA, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 1)};
    tbl[21] = '{1, 1, {9'b010_100_110, 7'd0}, mk(9'h1AA, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[22] = '{1, 0, 16'h0000,               mk(9'h0A6, 8'h08, 0, 0, 8'h00, 1, 0, 0, 0, 1)};
    tbl[23] = '{0, 0, 16'h0000,               mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[24] = '{1, 0, 16'h0000,               mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};
    tbl[25] = '{1, 0, 16'h0000,               mk(9'h000, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0)};

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rn, tbl[i].run, tbl[i].din, got);
      check($sformatf("vec%0d", i), got, tbl[i].exp);
    end

    // Randomized traffic: Run mostly high, occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      logic rn;
      logic run;
      logic [15:0] din;
      rn  = ($urandom_range(0, 39) != 0);
      run = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);
      step(rn, run, din, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
